// File: rtl/seq_normalizer_pkg.sv
// Shared encodings for the NORM/CLZ normalizer: FSM states, mode values and default width.
package norm_pkg;

   localparam int NORM_WIDTH = 16;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   localparam logic MODE_UNSIGNED = 1'b0;
   localparam logic MODE_SIGNED   = 1'b1;

   // Count must represent 0..width inclusive, hence one bit beyond clog2.
   function automatic int norm_cnt_w(input int width);
      return $clog2(width) + 1;
   endfunction

endpackage

// File: rtl/seq_normalizer_if.sv
// Start/busy/done request bus between the execute stage and the normalizer.
interface seq_normalizer_if
   import norm_pkg::*;
#(
   parameter int WIDTH = NORM_WIDTH
);
   localparam int CNT_W = norm_cnt_w(WIDTH);

   logic             start;
   logic [WIDTH-1:0] data;
   logic             mode;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] out;
   logic [CNT_W-1:0] count;

   modport master (
      output start, data, mode,
      input  busy, done, out, count
   );

   modport slave (
      input  start, data, mode,
      output busy, done, out, count
   );

endinterface

// File: rtl/seq_normalizer_stop_detect.sv
// Combinational termination test for one normalization step.
module norm_stop_detect
   import norm_pkg::*;
#(
   parameter  int WIDTH = NORM_WIDTH,
   localparam int CNT_W = norm_cnt_w(WIDTH)
) (
   input  logic [WIDTH-1:0] work_i,
   input  logic [CNT_W-1:0] cnt_i,
   input  logic             mode_i,
   output logic             stop_o
);

   // Signed stops one step earlier: the sign bit itself is never shifted out.
   always_comb begin
      stop_o = 1'b0;
      if (mode_i == MODE_SIGNED) begin
         stop_o = (work_i[WIDTH-1] != work_i[WIDTH-2]) ||
                  (cnt_i == CNT_W'(WIDTH-1));
      end else begin
         stop_o = work_i[WIDTH-1] || (cnt_i == CNT_W'(WIDTH));
      end
   end

endmodule

// File: rtl/seq_normalizer.sv
// Multi-cycle normalizer: shifts the operand left one bit per cycle until it is left-justified.
module seq_normalizer
   import norm_pkg::*;
#(
   parameter int WIDTH = NORM_WIDTH
) (
   input  logic              clk,
   input  logic              rst_n,
   seq_normalizer_if.slave   bus
);

   localparam int CNT_W = norm_cnt_w(WIDTH);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] work_q,  work_d;
   logic [CNT_W-1:0] cnt_q,   cnt_d;
   logic             mode_q,  mode_d;
   logic [WIDTH-1:0] out_q,   out_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             stop;

   norm_stop_detect #(.WIDTH(WIDTH)) u_stop (
      .work_i (work_q),
      .cnt_i  (cnt_q),
      .mode_i (mode_q),
      .stop_o (stop)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE:  if (bus.start) state_d = ST_SHIFT;
         ST_SHIFT: if (stop)      state_d = ST_DONE;
         ST_DONE:                 state_d = ST_IDLE;
         default:                 state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      bus.busy  = (state_q != ST_IDLE);
      bus.done  = (state_q == ST_DONE);
      bus.out   = out_q;
      bus.count = count_q;
   end

   // Result registers only move on the SHIFT->DONE edge so they hold between completions.
   always_comb begin
      work_d  = work_q;
      cnt_d   = cnt_q;
      mode_d  = mode_q;
      out_d   = out_q;
      count_d = count_q;
      if (state_q == ST_IDLE) begin
         if (bus.start) begin
            work_d = bus.data;
            mode_d = bus.mode;
            cnt_d  = '0;
         end
      end else if (state_q == ST_SHIFT) begin
         if (stop) begin
            out_d   = work_q;
            count_d = cnt_q;
         end else begin
            work_d = {work_q[WIDTH-2:0], 1'b0};
            cnt_d  = cnt_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         work_q  <= '0;
         cnt_q   <= '0;
         mode_q  <= MODE_UNSIGNED;
         out_q   <= '0;
         count_q <= '0;
      end else begin
         work_q  <= work_d;
         cnt_q   <= cnt_d;
         mode_q  <= mode_d;
         out_q   <= out_d;
         count_q <= count_d;
      end
   end

endmodule

// File: tb/tb_seq_normalizer.sv
// Directed bench for seq_normalizer: latency, results, handshake and async reset abort.
module tb_seq_normalizer;
   import norm_pkg::*;

   logic clk;
   logic rst_n;
   int   vecs;
   int   miscomp;

   seq_normalizer_if #(.WIDTH(16)) bus ();

   seq_normalizer #(.WIDTH(16)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vecs++;
      assert (obs === exp) else begin
         miscomp++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Drives start for one edge, counts edges (including the sampling edge) until done.
   task automatic do_op(input string tag, input logic [15:0] d, input logic m,
                        input int exp_cnt, input logic [15:0] exp_out);
      int   edges;
      bit   seen;
      logic [15:0] rt;
      bus.start = 1'b1;
      bus.data  = d;
      bus.mode  = m;
      @(posedge clk); #1;
      bus.start = 1'b0;
      edges = 1;
      seen  = 1'b0;
      chk({tag, "_busy0"}, 32'(bus.busy), 32'd1);
      while (!seen && edges < 40) begin
         if (bus.done === 1'b1) seen = 1'b1;
         else begin
            @(posedge clk); #1;
            edges++;
         end
      end
      chk({tag, "_done"},  32'(seen), 32'd1);
      chk({tag, "_lat"},   32'(edges), 32'(exp_cnt + 2));
      chk({tag, "_count"}, 32'(bus.count), 32'(exp_cnt));
      chk({tag, "_out"},   32'(bus.out), 32'(exp_out));
      if (exp_cnt < 16) begin
         if (m == MODE_SIGNED) rt = 16'($signed(bus.out) >>> bus.count);
         else                  rt = bus.out >> bus.count;
         chk({tag, "_rt"}, 32'(rt), 32'(d));
      end
   endtask

   initial begin
      int edges;
      int ndone;
      bit seen;
      vecs      = 0;
      miscomp   = 0;
      rst_n     = 1'b0;
      bus.start = 1'b0;
      bus.data  = '0;
      bus.mode  = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_busy",  32'(bus.busy),  32'd0);
      chk("rst_done",  32'(bus.done),  32'd0);
      chk("rst_out",   32'(bus.out),   32'd0);
      chk("rst_count", 32'(bus.count), 32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Minimum latency; busy must drop right after the done cycle.
      do_op("u8000", 16'h8000, MODE_UNSIGNED, 0, 16'h8000);
      @(posedge clk); #1;
      chk("u8000_idle_busy", 32'(bus.busy), 32'd0);
      chk("u8000_idle_done", 32'(bus.done), 32'd0);
      chk("u8000_hold_out",  32'(bus.out),  32'h8000);

      do_op("u0001", 16'h0001, MODE_UNSIGNED, 15, 16'h8000);
      @(posedge clk); #1;
      do_op("u0000", 16'h0000, MODE_UNSIGNED, 16, 16'h0000);
      @(posedge clk); #1;
      do_op("u00f0", 16'h00f0, MODE_UNSIGNED, 8, 16'hf000);
      @(posedge clk); #1;
      do_op("sfff0", 16'hfff0, MODE_SIGNED, 11, 16'h8000);
      @(posedge clk); #1;
      do_op("s0001", 16'h0001, MODE_SIGNED, 14, 16'h4000);
      @(posedge clk); #1;
      do_op("s0000", 16'h0000, MODE_SIGNED, 15, 16'h0000);
      @(posedge clk); #1;
      do_op("sffff", 16'hffff, MODE_SIGNED, 15, 16'h8000);
      @(posedge clk); #1;
      do_op("s4000", 16'h4000, MODE_SIGNED, 0, 16'h4000);
      @(posedge clk); #1;

      // Start pulsed while busy must be dropped, not queued.
      bus.start = 1'b1; bus.data = 16'h0001; bus.mode = MODE_UNSIGNED;
      @(posedge clk); #1;
      bus.start = 1'b0;
      edges = 1;
      repeat (4) begin @(posedge clk); #1; edges++; end
      bus.start = 1'b1; bus.data = 16'h8000;
      @(posedge clk); #1; edges++;
      bus.start = 1'b0;
      seen = 1'b0;
      while (!seen && edges < 40) begin
         if (bus.done === 1'b1) seen = 1'b1;
         else begin @(posedge clk); #1; edges++; end
      end
      chk("hs_done",  32'(seen), 32'd1);
      chk("hs_lat",   32'(edges), 32'd17);
      chk("hs_count", 32'(bus.count), 32'd15);
      chk("hs_out",   32'(bus.out), 32'h8000);
      // Start held through the done cycle: ignored at the DONE edge, taken on the next.
      bus.start = 1'b1; bus.data = 16'h2000; bus.mode = MODE_UNSIGNED;
      @(posedge clk); #1;
      chk("hs_done_ignore", 32'(bus.busy), 32'd0);
      do_op("hs_next", 16'h2000, MODE_UNSIGNED, 2, 16'h8000);
      @(posedge clk); #1;
      ndone = 0;
      repeat (20) begin
         if (bus.done === 1'b1) ndone++;
         @(posedge clk); #1;
      end
      chk("hs_single_done", 32'(ndone), 32'd0);

      // Asynchronous reset mid-operation aborts with no completion.
      bus.start = 1'b1; bus.data = 16'h0004; bus.mode = MODE_UNSIGNED;
      @(posedge clk); #1;
      bus.start = 1'b0;
      repeat (2) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("ar_busy",  32'(bus.busy),  32'd0);
      chk("ar_done",  32'(bus.done),  32'd0);
      chk("ar_out",   32'(bus.out),   32'd0);
      chk("ar_count", 32'(bus.count), 32'd0);
      @(posedge clk); #3;
      rst_n = 1'b1;
      ndone = 0;
      repeat (25) begin
         @(posedge clk); #1;
         if (bus.done === 1'b1) ndone++;
      end
      chk("ar_no_done", 32'(ndone), 32'd0);
      do_op("ar_next", 16'h0004, MODE_UNSIGNED, 13, 16'h8000);
      @(posedge clk); #1;

      $display("== %0d vectors applied, %0d miscompares ==", vecs, miscomp);
      $finish;
   end

endmodule
